// File: rtl/seq_detector_stim_gen.sv
// Stimulus source for the sequence-detector regression: a seeded Galois LFSR
// drives beats (IN_VALID/MODE/DATA_IN) with pseudo-random idle gaps between them.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for START after reset
// S_RUN  | every edge issues one beat and advances the LFSR
// S_GAP  | idle cycles between beats, gap_cnt counts down to zero
// S_DONE | run finished, DONE asserted, waiting for a new START
//
// Outputs are registered actions of the state that was current at the edge, so
// a beat issued in S_RUN shows BUSY=1 beside it.  DONE and BUSY=0 appear on the
// first edge spent in S_DONE, together with IN_VALID=0.
module seq_detector_stim_gen #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NUM_VECTORS = 1024,
  parameter int          GAP_MAX     = 3,
  parameter int          MODE_HOLD   = 64
) (
  input  logic        SYSCLK,
  input  logic        RST_B,
  input  logic        START,
  output logic        IN_VALID,
  output logic [1:0]  MODE,
  output logic [3:0]  DATA_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] VEC_COUNT
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] NUM_VEC   = 16'(NUM_VECTORS);
  localparam logic [1:0]  GAP_LIM   = 2'(GAP_MAX);
  localparam logic [15:0] HOLD_LOAD = 16'(MODE_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [1:0]  gap_cnt;
  logic [15:0] hold_cnt;
  logic [1:0]  mode_q;

  logic [15:0] lfsr_next;
  logic [1:0]  gap_sel;
  logic [15:0] count_inc;
  logic        last_beat;

  // Next LFSR value, gap length and beat bookkeeping from the pre-advance state.
  always_comb begin
    lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    gap_sel   = (lfsr[5:4] > GAP_LIM) ? GAP_LIM : lfsr[5:4];
    count_inc = VEC_COUNT + 16'd1;
    last_beat = (count_inc == NUM_VEC);
  end

  // Run-control FSM with all outputs registered.  mode_q is the pending mode;
  // MODE copies it one edge later so a change never lands on the beat that
  // triggered it.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state     <= S_IDLE;
      lfsr      <= SEED_EFF;
      gap_cnt   <= 2'd0;
      hold_cnt  <= HOLD_LOAD;
      mode_q    <= 2'd0;
      IN_VALID  <= 1'b0;
      MODE      <= 2'd0;
      DATA_IN   <= 4'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      VEC_COUNT <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          IN_VALID <= 1'b0;
          BUSY     <= 1'b0;
          DONE     <= (state == S_DONE);
          MODE     <= mode_q;
          if (START && !BUSY) begin
            lfsr      <= SEED_EFF;
            VEC_COUNT <= 16'd0;
            mode_q    <= 2'd0;
            MODE      <= 2'd0;
            DONE      <= 1'b0;
            hold_cnt  <= HOLD_LOAD;
            gap_cnt   <= 2'd0;
            state     <= (NUM_VEC == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          IN_VALID  <= 1'b1;
          DATA_IN   <= lfsr[3:0];
          VEC_COUNT <= count_inc;
          lfsr      <= lfsr_next;
          BUSY      <= 1'b1;
          DONE      <= 1'b0;
          MODE      <= mode_q;
          if (hold_cnt == 16'd0) begin
            mode_q   <= mode_q + 2'd1;
            hold_cnt <= HOLD_LOAD;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
          if (last_beat) begin
            state <= S_DONE;
          end else if (gap_sel != 2'd0) begin
            gap_cnt <= gap_sel;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          IN_VALID <= 1'b0;
          BUSY     <= 1'b1;
          DONE     <= 1'b0;
          MODE     <= mode_q;
          gap_cnt  <= gap_cnt - 2'd1;
          if (gap_cnt == 2'd1) begin
            state <= S_RUN;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detector_stim_gen.sv
// Directed, table-driven bench for seq_detector_stim_gen using four instances
// with different parameter sets sharing one clock and reset.
module tb_seq_detector_stim_gen;

  typedef struct packed {
    logic        iv;
    logic [3:0]  data;
    logic [1:0]  mode;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
  } vec_t;

  logic SYSCLK = 1'b0;
  logic RST_B  = 1'b0;
  logic start_d = 1'b0, start_a = 1'b0, start_b = 1'b0, start_z = 1'b0;

  logic d_iv, a_iv, b_iv, z_iv;
  logic [1:0] d_mode, a_mode, b_mode, z_mode;
  logic [3:0] d_data, a_data, b_data, z_data;
  logic d_busy, a_busy, b_busy, z_busy;
  logic d_done, a_done, b_done, z_done;
  logic [15:0] d_cnt, a_cnt, b_cnt, z_cnt;

  int total = 0;
  int bad = 0;

  vec_t tab_def [1:18];
  vec_t tab_a   [1:5];
  vec_t tab_b   [1:11];

  always #5 SYSCLK = ~SYSCLK;

  seq_detector_stim_gen u_def (
    .SYSCLK(SYSCLK), .RST_B(RST_B), .START(start_d), .IN_VALID(d_iv), .MODE(d_mode),
    .DATA_IN(d_data), .BUSY(d_busy), .DONE(d_done), .VEC_COUNT(d_cnt));

  seq_detector_stim_gen #(.GAP_MAX(0), .NUM_VECTORS(4)) u_a (
    .SYSCLK(SYSCLK), .RST_B(RST_B), .START(start_a), .IN_VALID(a_iv), .MODE(a_mode),
    .DATA_IN(a_data), .BUSY(a_busy), .DONE(a_done), .VEC_COUNT(a_cnt));

  seq_detector_stim_gen #(.GAP_MAX(0), .NUM_VECTORS(10), .MODE_HOLD(2)) u_b (
    .SYSCLK(SYSCLK), .RST_B(RST_B), .START(start_b), .IN_VALID(b_iv), .MODE(b_mode),
    .DATA_IN(b_data), .BUSY(b_busy), .DONE(b_done), .VEC_COUNT(b_cnt));

  seq_detector_stim_gen #(.NUM_VECTORS(0)) u_z (
    .SYSCLK(SYSCLK), .RST_B(RST_B), .START(start_z), .IN_VALID(z_iv), .MODE(z_mode),
    .DATA_IN(z_data), .BUSY(z_busy), .DONE(z_done), .VEC_COUNT(z_cnt));

  function automatic vec_t mk(input logic iv, input logic [3:0] data, input logic [1:0] mode,
                              input logic [15:0] cnt, input logic busy, input logic done);
    vec_t v;
    v.iv = iv; v.data = data; v.mode = mode; v.cnt = cnt; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input int idx, input vec_t exp,
                         input logic iv, input logic [3:0] data, input logic [1:0] mode,
                         input logic [15:0] cnt, input logic busy, input logic done);
    chk({name, ".in_valid"}, idx, 16'(iv), 16'(exp.iv));
    chk({name, ".data_in"}, idx, 16'(data), 16'(exp.data));
    chk({name, ".mode"}, idx, 16'(mode), 16'(exp.mode));
    chk({name, ".vec_count"}, idx, cnt, exp.cnt);
    chk({name, ".busy"}, idx, 16'(busy), 16'(exp.busy));
    chk({name, ".done"}, idx, 16'(done), 16'(exp.done));
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  initial begin
    logic [3:0] dseq [1:10];
    logic [1:0] mseq [1:10];

    // Default parameters: beats at edges 1,4,8,12,14,15,18 with gaps between.
    tab_def[1]  = mk(1, 4'h1, 0, 1, 1, 0);
    tab_def[2]  = mk(0, 4'h1, 0, 1, 1, 0);
    tab_def[3]  = mk(0, 4'h1, 0, 1, 1, 0);
    tab_def[4]  = mk(1, 4'h0, 0, 2, 1, 0);
    for (int e = 5; e <= 7; e++) tab_def[e] = mk(0, 4'h0, 0, 2, 1, 0);
    tab_def[8]  = mk(1, 4'h8, 0, 3, 1, 0);
    for (int e = 9; e <= 11; e++) tab_def[e] = mk(0, 4'h8, 0, 3, 1, 0);
    tab_def[12] = mk(1, 4'hC, 0, 4, 1, 0);
    tab_def[13] = mk(0, 4'hC, 0, 4, 1, 0);
    tab_def[14] = mk(1, 4'hE, 0, 5, 1, 0);
    tab_def[15] = mk(1, 4'h7, 0, 6, 1, 0);
    tab_def[16] = mk(0, 4'h7, 0, 6, 1, 0);
    tab_def[17] = mk(0, 4'h7, 0, 6, 1, 0);
    tab_def[18] = mk(1, 4'h3, 0, 7, 1, 0);

    // No gaps, four beats, then DONE.
    tab_a[1] = mk(1, 4'h1, 0, 1, 1, 0);
    tab_a[2] = mk(1, 4'h0, 0, 2, 1, 0);
    tab_a[3] = mk(1, 4'h8, 0, 3, 1, 0);
    tab_a[4] = mk(1, 4'hC, 0, 4, 1, 0);
    tab_a[5] = mk(0, 4'hC, 0, 4, 0, 1);

    // No gaps, MODE_HOLD=2, ten beats.
    dseq = '{4'h1, 4'h0, 4'h8, 4'hC, 4'hE, 4'h7, 4'h3, 4'h9, 4'h4, 4'h2};
    mseq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    for (int e = 1; e <= 10; e++) tab_b[e] = mk(1, dseq[e], mseq[e], 16'(e), 1, 0);
    tab_b[11] = mk(0, 4'h2, 2'd1, 16'd10, 0, 1);

    // Reset state while RST_B is held low.
    #20;
    chk_vec("reset_def", 0, mk(0, 0, 0, 0, 0, 0), d_iv, d_data, d_mode, d_cnt, d_busy, d_done);
    #2 RST_B = 1'b1;
    tick();
    tick();
    chk_vec("idle_def", 0, mk(0, 0, 0, 0, 0, 0), d_iv, d_data, d_mode, d_cnt, d_busy, d_done);

    // Default run; START pulses at edges 5 and 8 fall inside the run and are ignored.
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    chk_vec("def", 0, mk(0, 0, 0, 0, 0, 0), d_iv, d_data, d_mode, d_cnt, d_busy, d_done);
    for (int e = 1; e <= 18; e++) begin
      if (e == 5 || e == 8) start_d = 1'b1;
      tick();
      start_d = 1'b0;
      chk_vec("def", e, tab_def[e], d_iv, d_data, d_mode, d_cnt, d_busy, d_done);
    end

    // Four-beat run, then a restart from DONE must repeat it exactly.
    for (int r = 0; r < 2; r++) begin
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("run_a.start_done", r, 16'(a_done), 16'd0);
      chk("run_a.start_cnt", r, a_cnt, 16'd0);
      for (int e = 1; e <= 5; e++) begin
        tick();
        chk_vec(r == 0 ? "run_a" : "rerun_a", e, tab_a[e], a_iv, a_data, a_mode, a_cnt, a_busy, a_done);
      end
      for (int e = 0; e < 3; e++) tick();
      chk_vec("hold_a", r, tab_a[5], a_iv, a_data, a_mode, a_cnt, a_busy, a_done);
    end

    // MODE stepping every two beats.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      chk_vec("mode_b", e, tab_b[e], b_iv, b_data, b_mode, b_cnt, b_busy, b_done);
    end

    // Zero-length run goes straight to DONE.
    start_z = 1'b1;
    tick();
    start_z = 1'b0;
    chk("zero.done_edge0", 0, 16'(z_done), 16'd0);
    tick();
    chk_vec("zero", 1, mk(0, 0, 0, 0, 0, 1), z_iv, z_data, z_mode, z_cnt, z_busy, z_done);
    chk("zero.done_later", 1, 16'(z_done), 16'd1);

    // Asynchronous reset in the middle of a run clears everything before the next edge.
    for (int e = 0; e < 5; e++) tick();
    chk("pre_reset.busy", 0, 16'(d_busy), 16'd1);
    #2 RST_B = 1'b0;
    #1;
    chk_vec("async_rst_def", 0, mk(0, 0, 0, 0, 0, 0), d_iv, d_data, d_mode, d_cnt, d_busy, d_done);
    chk_vec("async_rst_a", 0, mk(0, 0, 0, 0, 0, 0), a_iv, a_data, a_mode, a_cnt, a_busy, a_done);
    #2 RST_B = 1'b1;
    tick();
    tick();
    chk_vec("post_rst_def", 0, mk(0, 0, 0, 0, 0, 0), d_iv, d_data, d_mode, d_cnt, d_busy, d_done);
    chk("post_rst_a.done", 0, 16'(a_done), 16'd0);

    // After reset the LFSR is back at the seed.
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    tick();
    chk_vec("restart_def", 1, tab_def[1], d_iv, d_data, d_mode, d_cnt, d_busy, d_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
